// File: rtl/hdmi_timing_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_timing_pkg
// Shared types, default 640x480 timing and sizing helpers for the HDMI timing
// engine. Imported by the interface, the divider and the top.
//
// Optional feature macro used by the engine: HDMI_TIMING_PREAMBLE_EN
// -----------------------------------------------------------------------------
package hdmi_timing_pkg;

    // Output mux period select, encoded exactly as the output mux expects it.
    typedef enum logic [1:0] {
        OS_BLANK    = 2'b00,
        OS_GUARD    = 2'b01,
        OS_VIDEO    = 2'b10,
        OS_PREAMBLE = 2'b11
    } outsel_t;

    // Default timing: 640x480 at 800x525 totals.
    localparam int DEF_CLK_DIV   = 6;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 43;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 0;
    localparam int DEF_GUARD_LEN = 2;
    localparam int DEF_ADDR_W    = 19;

    function automatic int h_total(int fp, int sync, int bp, int active);
        return fp + sync + bp + active;
    endfunction

    function automatic int v_total(int sync, int bp, int active, int fp);
        return sync + bp + active + fp;
    endfunction

    // Counter width able to hold 0..total-1 (never narrower than one bit).
    function automatic int cnt_width(int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/hdmi_timing_if.sv
// -----------------------------------------------------------------------------
// hdmi_timing_if
// Bundle between the timing engine and its consumers (framebuffer read port,
// serialiser, output mux).
//   enable        run request into the engine
//   pixel_tick    one-clk pulse per pixel period
//   colcount      current column        rowcount   current row
//   n_hsync       active-low hsync      n_vsync    active-low vsync
//   outputmuxsel  blank / guard / video / preamble
//   shift1load    load pulse, shift register 1
//   shift2load    load pulse, shift register 2
//   shiftmuxsel   serialiser source: 1 = reg1, 0 = reg2
//   pix_addr      framebuffer read address
//   frame_start   one-clk pulse on entering row 0, col 0
// Modports: master = timing engine, slave = consumer.
// Widths must match the engine parameters (defaults match default timing).
// -----------------------------------------------------------------------------
interface hdmi_timing_if
    import hdmi_timing_pkg::*;
#(
    parameter int COL_W  = cnt_width(h_total(DEF_H_FP, DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE)),
    parameter int ROW_W  = cnt_width(v_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP)),
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              enable;
    logic              pixel_tick;
    logic [COL_W-1:0]  colcount;
    logic [ROW_W-1:0]  rowcount;
    logic              n_hsync;
    logic              n_vsync;
    outsel_t           outputmuxsel;
    logic              shift1load;
    logic              shift2load;
    logic              shiftmuxsel;
    logic [ADDR_W-1:0] pix_addr;
    logic              frame_start;

    modport master (
        input  enable,
        output pixel_tick, colcount, rowcount, n_hsync, n_vsync, outputmuxsel,
               shift1load, shift2load, shiftmuxsel, pix_addr, frame_start
    );

    modport slave (
        output enable,
        input  pixel_tick, colcount, rowcount, n_hsync, n_vsync, outputmuxsel,
               shift1load, shift2load, shiftmuxsel, pix_addr, frame_start
    );

endinterface

// File: rtl/hdmi_timing_engine_pixel_tick_div.sv
// -----------------------------------------------------------------------------
// pixel_tick_div
// Pixel-clock-enable divider. The divider counts 0..CLK_DIV-1 while enable is
// high and holds while it is low; pixel_tick is registered and is high exactly
// in the clk where the divider sits at CLK_DIV-1.
//   clk, n_rst   system clock, asynchronous active-low reset
//   enable       count enable
//   pixel_tick   one-clk pulse per CLK_DIV enabled clks
// -----------------------------------------------------------------------------
module pixel_tick_div
    import hdmi_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    output logic pixel_tick
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("pixel_tick_div: CLK_DIV must be at least 2");
    end

    logic [DIV_W-1:0] div_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q      <= '0;
            pixel_tick <= 1'b0;
        end else if (enable) begin
            div_q      <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            // Decoded one count early so the registered tick coincides with
            // the divider holding its last value.
            pixel_tick <= (div_q == DIV_PRE);
        end else begin
            pixel_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hdmi_timing_engine.sv
// -----------------------------------------------------------------------------
// hdmi_timing_engine
// Parametrised HDMI/DVI output timing: pixel divider, row/column counters,
// sync, period select, ping-pong shift-register control and framebuffer read
// address. Every output is registered on pixel_tick and always describes the
// colcount/rowcount value it is presented with.
//   clk    system clock
//   n_rst  asynchronous active-low reset; the frame restarts at (0,0)
//   tif    hdmi_timing_if.master (enable in, all timing outputs out)
// Optional feature: `define HDMI_TIMING_PREAMBLE_EN to emit an 8-pixel control
// preamble (outputmuxsel = 11) just ahead of the guard band on active rows.
// -----------------------------------------------------------------------------
module hdmi_timing_engine
    import hdmi_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int GUARD_LEN = DEF_GUARD_LEN,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          n_rst,
    hdmi_timing_if.master tif
);

    localparam int H_TOTAL = h_total(H_FP, H_SYNC, H_BP, H_ACTIVE);
    localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int COL_W   = cnt_width(H_TOTAL);
    localparam int ROW_W   = cnt_width(V_TOTAL);

    // Boundaries sized to the counters; inclusive upper bounds so a bound equal
    // to a power-of-two total never overflows the counter width.
    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0]  HS_FIRST    = COL_W'(H_FP);
    localparam logic [COL_W-1:0]  HS_LAST     = COL_W'(H_FP + H_SYNC - 1);
    localparam logic [COL_W-1:0]  VID_FIRST   = COL_W'(H_TOTAL - H_ACTIVE);
    localparam logic [COL_W-1:0]  GUARD_FIRST = COL_W'(H_TOTAL - H_ACTIVE - GUARD_LEN);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0]  VS_END      = ROW_W'(V_SYNC);
    localparam logic [ROW_W-1:0]  ACT_FIRST   = ROW_W'(V_SYNC + V_BP);
    localparam logic [ROW_W-1:0]  ACT_LAST    = ROW_W'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(V_ACTIVE * H_ACTIVE - 1);

    if (GUARD_LEN > H_BP) begin : g_bad_guard
        $error("hdmi_timing_engine: GUARD_LEN must not exceed H_BP");
    end
    if (V_ACTIVE * H_ACTIVE > (1 << ADDR_W)) begin : g_bad_addr
        $error("hdmi_timing_engine: ADDR_W too narrow for the active frame");
    end

`ifdef HDMI_TIMING_PREAMBLE_EN
    localparam int PRE_LEN = 8;
    localparam logic [COL_W-1:0] PRE_FIRST = COL_W'(H_TOTAL - H_ACTIVE - GUARD_LEN - PRE_LEN);
    if (GUARD_LEN + PRE_LEN > H_BP) begin : g_bad_pre
        $error("hdmi_timing_engine: GUARD_LEN + 8 must not exceed H_BP with the preamble");
    end
`endif

    // ---------------------------------------------------------------- divider
    logic tick;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (tif.enable),
        .pixel_tick (tick)
    );

    // ------------------------------------------------------- registered state
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              hsync_q, vsync_q;
    outsel_t           os_q;
    logic              load1_q, load2_q, smux_q;
    logic [ADDR_W-1:0] addr_q;
    logic              frame_q;

    // ------------------------------------- next position and its decode
    // Outputs are decoded from the position the counters move to, so after
    // the tick edge every output matches the new colcount/rowcount.
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic              col_wrap, frame_d, row_act_d, hsync_d, vsync_d;
    outsel_t           os_d;
    logic [ADDR_W-1:0] addr_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        col_wrap = (col_q == COL_LAST);
        col_d    = col_wrap ? '0 : col_q + 1'b1;
        row_d    = row_q;
        if (col_wrap) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
        frame_d   = col_wrap && (row_q == ROW_LAST);

        hsync_d   = !((col_d >= HS_FIRST) && (col_d <= HS_LAST));
        vsync_d   = !(row_d < VS_END);
        row_act_d = (row_d >= ACT_FIRST) && (row_d <= ACT_LAST);

        os_d = OS_BLANK;
        if (row_act_d) begin
            if (col_d >= VID_FIRST) begin
                os_d = OS_VIDEO;
            end else if (col_d >= GUARD_FIRST) begin
                os_d = OS_GUARD;
            end
`ifdef HDMI_TIMING_PREAMBLE_EN
            else if (col_d >= PRE_FIRST) begin
                os_d = OS_PREAMBLE;
            end
`endif
        end

        // The address advances after each video pixel, so it always points at
        // the next pixel to fetch; the frame rollover restarts it.
        addr_d = addr_q;
        if (frame_d) begin
            addr_d = '0;
        end else if ((os_q == OS_VIDEO) && (addr_q != ADDR_LAST)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // ------------------------------------------------------- update on tick
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            os_q    <= OS_BLANK;
            load1_q <= 1'b0;
            load2_q <= 1'b0;
            smux_q  <= 1'b1;
            addr_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            // Pulses last one clk; they are re-raised only on a tick.
            load1_q <= 1'b0;
            load2_q <= 1'b0;
            frame_q <= 1'b0;
            if (tick) begin
                col_q   <= col_d;
                row_q   <= row_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                os_q    <= os_d;
                addr_q  <= addr_d;
                frame_q <= frame_d;
                // Ping-pong: swap the serialiser source and reload the register
                // just released (new select 0 -> reg1 free, 1 -> reg2 free).
                if (os_d != OS_BLANK) begin
                    smux_q  <= !smux_q;
                    load1_q <= smux_q;
                    load2_q <= !smux_q;
                end
            end
        end
    end

    assign tif.pixel_tick   = tick;
    assign tif.colcount     = col_q;
    assign tif.rowcount     = row_q;
    assign tif.n_hsync      = hsync_q;
    assign tif.n_vsync      = vsync_q;
    assign tif.outputmuxsel = os_q;
    assign tif.shift1load   = load1_q;
    assign tif.shift2load   = load2_q;
    assign tif.shiftmuxsel  = smux_q;
    assign tif.pix_addr     = addr_q;
    assign tif.frame_start  = frame_q;

endmodule

// File: tb/tb_hdmi_timing_engine.sv
// -----------------------------------------------------------------------------
// tb_hdmi_timing_engine
// Two engines share clock, reset and enable: a reduced-size configuration that
// is run through whole frames, and the default 640x480 configuration that is
// run through its first lines. A cycle model predicts every output of both
// engines; directed checks cover reset, frame_start timing, the address
// boundaries, an enable pause and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_hdmi_timing_engine;
    import hdmi_timing_pkg::*;

    typedef struct packed {
        int div; int hfp; int hsync; int hbp; int hact;
        int vsync; int vbp; int vact; int vfp; int guard;
    } cfg_t;

    typedef struct packed {
        int div; bit tick; int col; int row;
        bit hs; bit vs; logic [1:0] os; bit l1; bit l2; bit sm;
        int addr; bit fs;
    } model_t;

    // Reduced configuration: H_TOTAL 27, V_TOTAL 9, video cols 19..26,
    // guard 17..18, preamble 9..16, hsync 3..6, active rows 4..7.
    localparam cfg_t CS = '{div:2, hfp:3, hsync:4, hbp:12, hact:8,
                            vsync:2, vbp:2, vact:4, vfp:1, guard:2};
    localparam cfg_t CD = '{div:6, hfp:16, hsync:96, hbp:48, hact:640,
                            vsync:2, vbp:43, vact:480, vfp:0, guard:2};
    localparam int S_FRAME_CLKS = 2 * 27 * 9;   // 486

`ifdef HDMI_TIMING_PREAMBLE_EN
    localparam logic [1:0] PRE_OS = 2'b11;
`else
    localparam logic [1:0] PRE_OS = 2'b00;
`endif

    logic tb_pixelclk = 1'b0;
    logic n_rst;
    logic enable;
    bit   checking = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    model_t ms, md;

    always #5 tb_pixelclk = ~tb_pixelclk;

    hdmi_timing_if #(.COL_W(5), .ROW_W(4), .ADDR_W(19)) tif_s ();
    hdmi_timing_if tif_d ();

    assign tif_s.enable = enable;
    assign tif_d.enable = enable;

    hdmi_timing_engine #(
        .CLK_DIV(2), .H_FP(3), .H_SYNC(4), .H_BP(12), .H_ACTIVE(8),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1), .GUARD_LEN(2), .ADDR_W(19)
    ) dut_s (
        .clk   (tb_pixelclk),
        .n_rst (n_rst),
        .tif   (tif_s)
    );

    hdmi_timing_engine dut_d (
        .clk   (tb_pixelclk),
        .n_rst (n_rst),
        .tif   (tif_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [1:0] exp_os(cfg_t c, int row, int col);
        int ha0 = c.hfp + c.hsync + c.hbp;
        bit arow = (row >= c.vsync + c.vbp) && (row < c.vsync + c.vbp + c.vact);
        if (arow && col >= ha0) return 2'b10;
        if (arow && col >= ha0 - c.guard) return 2'b01;
        if (arow && col >= ha0 - c.guard - 8) return PRE_OS;
        return 2'b00;
    endfunction

    // Video positions strictly before (row,col) in the frame, saturated.
    function automatic int exp_addr(cfg_t c, int row, int col);
        int ha0 = c.hfp + c.hsync + c.hbp;
        int vr0 = c.vsync + c.vbp;
        int last = c.vact * c.hact - 1;
        int n;
        if (row < vr0) return 0;
        if (row >= vr0 + c.vact) n = c.vact * c.hact;
        else begin
            n = (row - vr0) * c.hact;
            if (col > ha0) n += col - ha0;
        end
        return (n > last) ? last : n;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m = '0;
        m.hs = 1'b1; m.vs = 1'b1; m.sm = 1'b1;
        return m;
    endfunction

    function automatic model_t step(cfg_t c, model_t m, logic en);
        model_t n = m;
        int ht = c.hfp + c.hsync + c.hbp + c.hact;
        int vt = c.vsync + c.vbp + c.vact + c.vfp;
        n.l1 = 1'b0; n.l2 = 1'b0; n.fs = 1'b0;
        if (m.tick) begin
            n.col = (m.col == ht - 1) ? 0 : m.col + 1;
            if (m.col == ht - 1) n.row = (m.row == vt - 1) ? 0 : m.row + 1;
            n.hs   = !(n.col >= c.hfp && n.col < c.hfp + c.hsync);
            n.vs   = !(n.row < c.vsync);
            n.os   = exp_os(c, n.row, n.col);
            n.fs   = (n.row == 0) && (n.col == 0);
            n.addr = exp_addr(c, n.row, n.col);
            if (n.os != 2'b00) begin
                n.sm = !m.sm;
                n.l1 = !n.sm;
                n.l2 = n.sm;
            end
        end
        if (en) begin
            n.div  = (m.div + 1) % c.div;
            n.tick = (n.div == c.div - 1);
        end else begin
            n.tick = 1'b0;
        end
        return n;
    endfunction

    always @(posedge tb_pixelclk or negedge n_rst) begin
        if (!n_rst) begin
            ms = model_reset();
            md = model_reset();
        end else begin
            ms = step(CS, ms, enable);
            md = step(CD, md, enable);
        end
    end

    task automatic cmp_dut(input string p, input model_t m, input logic tick,
                           input int col, input int row, input logic hs, input logic vs,
                           input logic [1:0] os, input logic l1, input logic l2,
                           input logic sm, input int addr, input logic fs);
        check({p, ".tick"}, tick, m.tick);
        check({p, ".col"},  col,  m.col);
        check({p, ".row"},  row,  m.row);
        check({p, ".n_hsync"}, hs, m.hs);
        check({p, ".n_vsync"}, vs, m.vs);
        check({p, ".outsel"}, os, m.os);
        check({p, ".load1"}, l1, m.l1);
        check({p, ".load2"}, l2, m.l2);
        check({p, ".shiftmuxsel"}, sm, m.sm);
        check({p, ".pix_addr"}, addr, m.addr);
        check({p, ".frame_start"}, fs, m.fs);
    endtask

    always @(negedge tb_pixelclk) begin
        if (checking) begin
            cmp_dut("s", ms, tif_s.pixel_tick, tif_s.colcount, tif_s.rowcount,
                    tif_s.n_hsync, tif_s.n_vsync, tif_s.outputmuxsel, tif_s.shift1load,
                    tif_s.shift2load, tif_s.shiftmuxsel, tif_s.pix_addr, tif_s.frame_start);
            cmp_dut("d", md, tif_d.pixel_tick, tif_d.colcount, tif_d.rowcount,
                    tif_d.n_hsync, tif_d.n_vsync, tif_d.outputmuxsel, tif_d.shift1load,
                    tif_d.shift2load, tif_d.shiftmuxsel, tif_d.pix_addr, tif_d.frame_start);
        end
    end

    // Wait (bounded) until the reduced engine shows (row,col) at a negedge.
    task automatic wait_pos(input int row, input int col, input string tag);
        bit found = 1'b0;
        int n = 0;
        while (!found && n < 1000) begin
            @(negedge tb_pixelclk);
            n++;
            found = (tif_s.rowcount == row) && (tif_s.colcount == col);
        end
        check({tag, ".reached"}, 32'(found), 1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int fs_count;
        int first_fs;
        n_rst  = 1'b0;
        enable = 1'b0;
        ms = model_reset();
        md = model_reset();
        repeat (2) @(negedge tb_pixelclk);
        checking = 1'b1;
        @(negedge tb_pixelclk);

        // Reset state.
        check("rst.s.col", tif_s.colcount, 0);
        check("rst.s.row", tif_s.rowcount, 0);
        check("rst.s.n_hsync", tif_s.n_hsync, 1);
        check("rst.s.n_vsync", tif_s.n_vsync, 1);
        check("rst.s.outsel", tif_s.outputmuxsel, 0);
        check("rst.s.shiftmuxsel", tif_s.shiftmuxsel, 1);
        check("rst.d.col", tif_d.colcount, 0);
        check("rst.d.row", tif_d.rowcount, 0);
        check("rst.d.n_hsync", tif_d.n_hsync, 1);
        check("rst.d.n_vsync", tif_d.n_vsync, 1);
        check("rst.d.outsel", tif_d.outputmuxsel, 0);
        check("rst.d.shiftmuxsel", tif_d.shiftmuxsel, 1);

        // Two reduced frames; default engine hsync edges at cols 16 and 112.
        n_rst    = 1'b1;
        enable   = 1'b1;
        fs_count = 0;
        first_fs = 0;
        for (int i = 1; i <= 2 * S_FRAME_CLKS; i++) begin
            @(negedge tb_pixelclk);
            if (tif_s.frame_start) begin
                fs_count++;
                if (first_fs == 0) first_fs = i;
            end
            if (i == 95)  check("d.hsync_before", tif_d.n_hsync, 1);
            if (i == 96)  check("d.hsync_first", tif_d.n_hsync, 0);
            if (i == 671) check("d.hsync_last", tif_d.n_hsync, 0);
            if (i == 672) check("d.hsync_after", tif_d.n_hsync, 1);
        end
        check("s.frame_starts", fs_count, 2);
        check("s.first_frame_start", first_fs, S_FRAME_CLKS);

        // Period boundaries and address limits on the next frame.
        wait_pos(4, 12, "pre");
        check("s.preamble_outsel", tif_s.outputmuxsel, PRE_OS);
        wait_pos(4, 18, "guard");
        check("s.guard_outsel", tif_s.outputmuxsel, 1);
        wait_pos(4, 19, "video0");
        check("s.video_outsel", tif_s.outputmuxsel, 2);
        check("s.first_addr", tif_s.pix_addr, 0);
        wait_pos(7, 26, "lastpix");
        check("s.last_addr", tif_s.pix_addr, 31);
        wait_pos(8, 0, "frontporch");
        check("s.sat_addr", tif_s.pix_addr, 31);
        wait_pos(0, 0, "rollover");
        check("s.rollover_fs", tif_s.frame_start, 1);
        check("s.rollover_addr", tif_s.pix_addr, 0);

        // Enable pause at col 20 for 50 clks.
        wait_pos(0, 20, "pause");
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge tb_pixelclk);
            check("pause.col", tif_s.colcount, 20);
            check("pause.tick", tif_s.pixel_tick, 0);
            check("pause.loads", {tif_s.shift1load, tif_s.shift2load}, 0);
        end
        enable = 1'b1;
        repeat (2) @(negedge tb_pixelclk);
        check("resume.col", tif_s.colcount, 21);

        // Mid-frame reset, then one full frame to the next frame_start.
        wait_pos(5, 10, "midreset");
        #2 n_rst = 1'b0;
        #1;
        check("mrst.col", tif_s.colcount, 0);
        check("mrst.row", tif_s.rowcount, 0);
        check("mrst.n_hsync", tif_s.n_hsync, 1);
        check("mrst.n_vsync", tif_s.n_vsync, 1);
        check("mrst.outsel", tif_s.outputmuxsel, 0);
        check("mrst.shiftmuxsel", tif_s.shiftmuxsel, 1);
        check("mrst.pix_addr", tif_s.pix_addr, 0);
        check("mrst.d.col", tif_d.colcount, 0);
        repeat (3) @(negedge tb_pixelclk);
        n_rst    = 1'b1;
        first_fs = 0;
        for (int i = 1; i <= S_FRAME_CLKS + 100 && first_fs == 0; i++) begin
            @(negedge tb_pixelclk);
            if (tif_s.frame_start) first_fs = i;
        end
        check("mrst.frame_start_delay", first_fs, S_FRAME_CLKS);

        repeat (4) @(negedge tb_pixelclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
